fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters using valid/ready handshakes. It grants one requester at a time for a burst of up to BURST_LEN beats and registers the winning beat onto the FIFO write port. A local credit counter tracks FIFO free space, so no write is ever issued into a full FIFO regardless of flag latency. It sits directly in front of the team's sync FIFO write side.

---
 rtl/fifo_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ requesters, credit-gated.
// Optional FIFO_ARB_STATS_EN adds a saturating beat_total transfer counter port.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_pop,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
`ifdef FIFO_ARB_STATS_EN
  output logic [15:0]                   beat_total,
`endif
  output logic                          credit_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                  state_q;
  logic [GW-1:0]           grant_id_q;
  logic [GW-1:0]           last_grant_q;
  logic [BW-1:0]           beat_cnt_q;
  logic [CW-1:0]           credits_q;
  logic [CW-1:0]           credits_d;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    credit_err_q;

  logic                    any_valid;
  logic [GW-1:0]           sel_d;
  logic                    found;
  int                      idx;
  logic                    cur_valid;
  logic [DATA_WIDTH-1:0]   cur_data;
  logic                    has_credit;
  logic                    xfer;
  logic                    pop_ok;
  logic                    pop_over;

  assign any_valid  = |req_valid;
  assign has_credit = (credits_q != '0);
  assign xfer       = (state_q == BURST) && cur_valid && has_credit;
  assign pop_ok     = fifo_pop && (credits_q != CRED_FULL);
  assign pop_over   = fifo_pop && (credits_q == CRED_FULL);

  // Rotating priority: search upward starting just after the last winner.
  always_comb begin
    sel_d = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel_d = GW'(idx);
      end
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == GW'(i)) begin
        cur_valid = req_valid[i];
        cur_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready depends only on registered state and credits, never on req_valid.
  always_comb begin
    req_ready = '0;
    if (state_q == BURST && has_credit) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == GW'(i)) req_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    credits_d = credits_q;
    case ({xfer, pop_ok})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
      credits_q    <= CRED_FULL;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      credits_q <= credits_d;
      wr_en_q   <= xfer;
      if (xfer) wr_data_q <= cur_data;
      if (pop_over) credit_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (any_valid && found) begin
            grant_id_q   <= sel_d;
            last_grant_q <= sel_d;
            beat_cnt_q   <= '0;
            state_q      <= BURST;
          end
        end
        BURST: begin
          if (!cur_valid) begin
            state_q <= IDLE;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_total_q <= '0;
    end else if (xfer && beat_total_q != 16'hFFFF) begin
      beat_total_q <= beat_total_q + 16'd1;
    end
  end

  assign beat_total = beat_total_q;
`endif

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign grant_valid  = (state_q == BURST);
  assign grant_id     = grant_id_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: bursts, rotation, credit stall, credit error, async reset.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_pop = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        credit_err;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beat_total;
`endif

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .FIFO_DEPTH(16), .BURST_LEN(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_pop(fifo_pop), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_valid(grant_valid), .grant_id(grant_id),
`ifdef FIFO_ARB_STATS_EN
    .beat_total(beat_total),
`endif
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cnt[4];
  int nb[4];
  logic [3:0] en;
  logic pop_mode;
  int occ, cyc, nwr, ng;
  logic prev_gv;
  logic [7:0] wr_log[64];
  int wr_cyc[64];
  logic [1:0] gnt_log[16];
  int gnt_cyc[16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && (cnt[i] < nb[i]);
      req_data[i*8 +: 8] = 8'hA0 + 8'(16 * i) + 8'(cnt[i]);
    end
  endtask

  task automatic cycle();
    logic [3:0] hs;
    logic wr_pend;
    logic pop_now;
    hs = req_valid & req_ready;
    wr_pend = fifo_wr_en;
    pop_now = fifo_pop;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
    if (wr_pend) occ++;
    if (pop_now && occ > 0) occ--;
    if (fifo_wr_en && nwr < 64) begin
      wr_log[nwr] = fifo_wr_data;
      wr_cyc[nwr] = cyc;
      nwr++;
    end
    if (grant_valid && !prev_gv && ng < 16) begin
      gnt_log[ng] = grant_id;
      gnt_cyc[ng] = cyc;
      ng++;
    end
    prev_gv = grant_valid;
    fifo_pop = pop_mode && (occ > 0);
    drive();
  endtask

  task automatic clear_logs();
    ng = 0; nwr = 0; occ = 0; cyc = 0; prev_gv = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = '0; pop_mode = 1'b0; fifo_pop = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nb[i] = 0; end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    int guard;
    en = '0; pop_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nb[i] = 0; end
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_gvalid", 32'(grant_valid), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_credits", 32'(dut.credits_q), 32'd16);
    rst = 1'b0;

    // Single requester, 6 beats, no pops
    do_reset();
    en = 4'b0001; nb[0] = 6; drive();
    repeat (15) cycle();
    chk("t1_nwr", 32'(nwr), 32'd6);
    for (int k = 0; k < 6; k++) chk($sformatf("t1_data%0d", k), 32'(wr_log[k]), 32'(8'hA0 + k));
    chk("t1_run", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
    chk("t1_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);
    chk("t1_ngrant", 32'(ng), 32'd2);
    chk("t1_credits", 32'(dut.credits_q), 32'd10);

    // All four requesting, FIFO drained every cycle
    do_reset();
    en = 4'b1111; nb[0] = 8; nb[1] = 4; nb[2] = 4; nb[3] = 4; pop_mode = 1'b1; drive();
    repeat (40) cycle();
    chk("t2_ngrant", 32'(ng), 32'd5);
    chk("t2_g0", 32'(gnt_log[0]), 32'd0);
    chk("t2_g1", 32'(gnt_log[1]), 32'd1);
    chk("t2_g2", 32'(gnt_log[2]), 32'd2);
    chk("t2_g3", 32'(gnt_log[3]), 32'd3);
    chk("t2_g4", 32'(gnt_log[4]), 32'd0);
    for (int k = 1; k < 5; k++) chk($sformatf("t2_period%0d", k), 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd5);
    chk("t2_nwr", 32'(nwr), 32'd20);
    for (int k = 0; k < 20; k++) begin
      if (k < 16) chk($sformatf("t2_data%0d", k), 32'(wr_log[k]), 32'(8'hA0 + 16 * (k / 4) + (k % 4)));
      else        chk($sformatf("t2_data%0d", k), 32'(wr_log[k]), 32'(8'hA0 + (k - 12)));
    end
    chk("t2_credits", 32'(dut.credits_q), 32'd16);
    chk("t2_err", 32'(credit_err), 32'd0);

    // Credit exhaustion and single-pop release
    do_reset();
    en = 4'b0001; nb[0] = 40; drive();
    repeat (30) cycle();
    chk("t3_cnt16", 32'(cnt[0]), 32'd16);
    chk("t3_credits0", 32'(dut.credits_q), 32'd0);
    chk("t3_ready0", 32'(req_ready), 32'd0);
    chk("t3_gvalid", 32'(grant_valid), 32'd1);
    fifo_pop = 1'b1;
    cycle();
    chk("t3_ready_after_pop", 32'(req_ready), 32'b0001);
    repeat (8) cycle();
    chk("t3_cnt17", 32'(cnt[0]), 32'd17);
    chk("t3_credits_end", 32'(dut.credits_q), 32'd0);

    // Transfer and pop in the same cycle at credits=5
    do_reset();
    en = 4'b0001; nb[0] = 11; drive();
    repeat (20) cycle();
    chk("t4_credits5", 32'(dut.credits_q), 32'd5);
    nb[0] = 12; drive();
    guard = 0;
    while (!(req_valid[0] && req_ready[0]) && guard < 10) begin cycle(); guard++; end
    chk("t4_ready_seen", 32'(req_valid[0] && req_ready[0]), 32'd1);
    fifo_pop = 1'b1;
    cycle();
    chk("t4_cnt12", 32'(cnt[0]), 32'd12);
    chk("t4_credits_same", 32'(dut.credits_q), 32'd5);

    // Pop while credits are full
    do_reset();
    chk("t5_err_pre", 32'(credit_err), 32'd0);
    fifo_pop = 1'b1;
    cycle();
    chk("t5_credits16", 32'(dut.credits_q), 32'd16);
    chk("t5_err_set", 32'(credit_err), 32'd1);
    repeat (3) cycle();
    chk("t5_err_sticky", 32'(credit_err), 32'd1);
    do_reset();
    chk("t5_err_cleared", 32'(credit_err), 32'd0);

    // Asynchronous reset mid-burst after 2 beats
    do_reset();
    en = 4'b0001; nb[0] = 10; drive();
    guard = 0;
    while (cnt[0] < 2 && guard < 20) begin cycle(); guard++; end
    chk("t6_two_beats", 32'(cnt[0]), 32'd2);
    chk("t6_wr_pending", 32'(fifo_wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("t6_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("t6_gvalid", 32'(grant_valid), 32'd0);
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_credits", 32'(dut.credits_q), 32'd16);
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nb[i] = 4; end
    en = 4'b0011; drive();
    clear_logs();
    #2;
    rst = 1'b0;
    guard = 0;
    while (ng == 0 && guard < 10) begin cycle(); guard++; end
    chk("t6_granted", 32'(ng), 32'd1);
    chk("t6_next_gid", 32'(gnt_log[0]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
